// File: rtl/csr_sync_write.sv
// Carries one CSR write from cclk into frame_clk using a toggle req/ack handshake.
// The data word is held stable in cclk while busy, so only the toggle bit is synchronised.
module csr_sync_write #(
  parameter int unsigned            WIDTH       = 32,
  parameter logic [WIDTH-1:0]       RESET_VALUE = '0
) (
  input  logic             frame_clk,
  input  logic             frame_rst_b,
  input  logic             cclk,
  input  logic             rst_b_cclk,
  input  logic             wr_strobe_cclk,
  input  logic [WIDTH-1:0] wr_data_cclk,
  output logic             wr_wait_cclk,
  output logic             wr_done_strobe_cclk,
  output logic             wr_strobe_tclk,
  output logic [WIDTH-1:0] wr_data_tclk
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } cstate_e;

  // cclk domain
  cstate_e          state_q, state_d;
  logic             req_tgl_q, req_tgl_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             done_q, done_d;
  logic             a1_q, a2_q;

  // frame_clk domain
  logic             s1_q, s2_q;
  logic             ack_tgl_q;
  logic             tstrobe_q;
  logic [WIDTH-1:0] tdata_q;
  logic             new_req;

  always_ff @(posedge cclk or negedge rst_b_cclk) begin
    if (!rst_b_cclk) begin
      state_q   <= ST_IDLE;
      req_tgl_q <= 1'b0;
      hold_q    <= '0;
      done_q    <= 1'b0;
      a1_q      <= 1'b0;
      a2_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_tgl_q <= req_tgl_d;
      hold_q    <= hold_d;
      done_q    <= done_d;
      a1_q      <= ack_tgl_q;
      a2_q      <= a1_q;
    end
  end

  // Strobes arriving while busy fall through the default assignments and are dropped.
  always_comb begin
    state_d   = state_q;
    req_tgl_d = req_tgl_q;
    hold_d    = hold_q;
    done_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (wr_strobe_cclk) begin
          hold_d    = wr_data_cclk;
          req_tgl_d = ~req_tgl_q;
          state_d   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (a2_q == req_tgl_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign wr_wait_cclk        = (state_q == ST_BUSY) | wr_strobe_cclk;
  assign wr_done_strobe_cclk = done_q;

  // ack_tgl doubles as the third flop behind the synchroniser for edge detection.
  assign new_req = s2_q ^ ack_tgl_q;

  always_ff @(posedge frame_clk or negedge frame_rst_b) begin
    if (!frame_rst_b) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      ack_tgl_q <= 1'b0;
      tstrobe_q <= 1'b0;
      tdata_q   <= RESET_VALUE;
    end else begin
      s1_q      <= req_tgl_q;
      s2_q      <= s1_q;
      ack_tgl_q <= s2_q;
      tstrobe_q <= new_req;
      if (new_req) begin
        tdata_q <= hold_q;
      end
    end
  end

  assign wr_strobe_tclk = tstrobe_q;
  assign wr_data_tclk   = tdata_q;

endmodule

// File: tb/tb_csr_sync_write.sv
// Directed and table-driven bench for csr_sync_write with a scoreboard on the frame_clk side.
module tb_csr_sync_write;

  localparam int unsigned W  = 32;
  localparam logic [31:0] RV = 32'h0000_1234;

  logic          frame_clk = 1'b0;
  logic          cclk = 1'b0;
  logic          frame_rst_b = 1'b0;
  logic          rst_b_cclk = 1'b0;
  logic          wr_strobe_cclk = 1'b0;
  logic [W-1:0]  wr_data_cclk = '0;
  logic          wr_wait_cclk;
  logic          wr_done_strobe_cclk;
  logic          wr_strobe_tclk;
  logic [W-1:0]  wr_data_tclk;

  csr_sync_write #(.WIDTH(W), .RESET_VALUE(RV)) dut (
    .frame_clk           (frame_clk),
    .frame_rst_b         (frame_rst_b),
    .cclk                (cclk),
    .rst_b_cclk          (rst_b_cclk),
    .wr_strobe_cclk      (wr_strobe_cclk),
    .wr_data_cclk        (wr_data_cclk),
    .wr_wait_cclk        (wr_wait_cclk),
    .wr_done_strobe_cclk (wr_done_strobe_cclk),
    .wr_strobe_tclk      (wr_strobe_tclk),
    .wr_data_tclk        (wr_data_tclk)
  );

  int cclk_half = 5;
  int fclk_half = 5;
  int fskew     = 2;

  always begin
    #(cclk_half);
    cclk = ~cclk;
  end

  always begin
    if (fskew > 0) begin
      #(fskew);
      fskew = 0;
    end
    #(fclk_half);
    frame_clk = ~frame_clk;
  end

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  int strobe_cnt = 0;
  int done_cnt = 0;
  int accepted = 0;
  int fcnt = 0;
  int last_strobe_fcnt = 0;
  int t_accept = 0;
  logic [31:0] prev_data = '0;
  bit prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  always @(posedge frame_clk) fcnt++;

  // frame_clk scoreboard: each strobe must deliver the next accepted value intact.
  always @(negedge frame_clk) begin
    if (frame_rst_b) begin
      if (wr_strobe_tclk) begin
        strobe_cnt++;
        last_strobe_fcnt = fcnt;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_tclk_strobe: got data %h expected no strobe", wr_data_tclk);
        end else begin
          check("tclk_data", wr_data_tclk, exp_q.pop_front());
        end
      end else if (prev_valid && (wr_data_tclk !== prev_data)) begin
        check("tclk_data_stable", wr_data_tclk, prev_data);
      end
      prev_data  = wr_data_tclk;
      prev_valid = 1'b1;
    end else begin
      prev_valid = 1'b0;
    end
  end

  always @(negedge cclk) begin
    if (rst_b_cclk && wr_done_strobe_cclk) begin
      done_cnt++;
      check("done_not_extra", 32'(done_cnt <= accepted), 32'd1);
      check("wait_low_at_done", 32'(wr_wait_cclk), 32'd0);
    end
  end

  task automatic do_write(input logic [31:0] d, input bit will_accept);
    @(negedge cclk);
    wr_strobe_cclk = 1'b1;
    wr_data_cclk   = d;
    if (will_accept) begin
      exp_q.push_back(d);
      accepted++;
    end
    #1;
    check("wait_immediate", 32'(wr_wait_cclk), 32'd1);
    @(posedge cclk);
    #1;
    t_accept       = fcnt;
    wr_strobe_cclk = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int start;
    bit ok;
    start = done_cnt;
    ok    = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge cclk);
      #1;
      if (done_cnt > start) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got no done pulse expected one within 400 cclk cycles", name);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    logic [31:0] exp_final;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    vecs[0] = '{32'h0000_0010, 32'h0000_0010};
    vecs[1] = '{32'h0000_0020, 32'h0000_0020};
    vecs[2] = '{32'h0000_0030, 32'h0000_0030};
    vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[4] = '{32'h0000_0000, 32'h0000_0000};
    vecs[5] = '{32'h8000_0001, 32'h8000_0001};

    #23;
    frame_rst_b = 1'b1;
    rst_b_cclk  = 1'b1;
    repeat (3) @(negedge cclk);
    #1;
    check("reset_data", wr_data_tclk, RV);
    check("reset_tclk_strobe", 32'(wr_strobe_tclk), 32'd0);
    check("reset_done", 32'(wr_done_strobe_cclk), 32'd0);
    check("reset_wait", 32'(wr_wait_cclk), 32'd0);

    // Single write, same-frequency clocks, with latency measured in frame_clk edges.
    do_write(32'hDEAD_BEEF, 1'b1);
    wait_done("single_done");
    check("single_latency", 32'(last_strobe_fcnt - t_accept), 32'd3);
    check("single_value", wr_data_tclk, 32'hDEAD_BEEF);
    @(negedge cclk);
    #1;
    check("single_wait_after", 32'(wr_wait_cclk), 32'd0);
    check("single_counts", 32'(strobe_cnt), 32'(accepted));

    // Back-to-back: second strobe lands while busy and must vanish.
    @(negedge cclk);
    wr_strobe_cclk = 1'b1;
    wr_data_cclk   = 32'h1;
    exp_q.push_back(32'h1);
    accepted++;
    @(posedge cclk);
    #1;
    wr_data_cclk = 32'h2;
    check("b2b_wait", 32'(wr_wait_cclk), 32'd1);
    @(posedge cclk);
    #1;
    wr_strobe_cclk = 1'b0;
    wait_done("b2b_done");
    repeat (20) @(negedge cclk);
    check("b2b_value", wr_data_tclk, 32'h1);
    check("b2b_strobes", 32'(strobe_cnt), 32'(accepted));
    check("b2b_dones", 32'(done_cnt), 32'(accepted));

    foreach (vecs[i]) begin
      do_write(vecs[i].data, 1'b1);
      wait_done("table_done");
      check("table_value", wr_data_tclk, vecs[i].exp_final);
    end
    check("table_strobes", 32'(strobe_cnt), 32'(accepted));
    check("table_dones", 32'(done_cnt), 32'(accepted));

    // Ratio runs: fast frame_clk, then slow frame_clk, each with a random phase step.
    for (int r = 0; r < 2; r++) begin
      cclk_half = (r == 0) ? 15 : 5;
      fclk_half = (r == 0) ? 5 : 15;
      fskew     = int'($urandom_range(1, 9));
      repeat (4) @(negedge cclk);
      for (int n = 0; n < 100; n++) begin
        repeat ($urandom_range(0, 3)) @(negedge cclk);
        do_write($urandom, 1'b1);
        wait_done("ratio_done");
      end
      repeat (10) @(negedge cclk);
      check("ratio_strobes", 32'(strobe_cnt), 32'(accepted));
      check("ratio_dones", 32'(done_cnt), 32'(accepted));
      check("ratio_queue_empty", 32'(exp_q.size()), 32'd0);
    end

    // Reset both domains while a write is in flight.
    cclk_half = 5;
    fclk_half = 5;
    repeat (4) @(negedge cclk);
    d0 = done_cnt;
    do_write(32'h0000_0077, 1'b0);
    frame_rst_b = 1'b0;
    rst_b_cclk  = 1'b0;
    #40;
    frame_rst_b = 1'b1;
    rst_b_cclk  = 1'b1;
    repeat (20) @(negedge cclk);
    #1;
    check("rst_mid_no_done", 32'(done_cnt), 32'(d0));
    check("rst_mid_data", wr_data_tclk, RV);
    check("rst_mid_wait", 32'(wr_wait_cclk), 32'd0);
    do_write(32'hCAFE_F00D, 1'b1);
    wait_done("post_rst_done");
    check("post_rst_value", wr_data_tclk, 32'hCAFE_F00D);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    check("final_strobes", 32'(strobe_cnt), 32'(accepted));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
